// File: rtl/wr_ingress_pkg.sv
// Shared types and constants for the async FIFO write-side ingress stage.
package wr_ingress_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } ingress_state_t;

    // All-ones value of a w-bit counter; saturates at 64 bits.
    function automatic logic [63:0] cnt_max(input int unsigned w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = CNT_W_DEFAULT'(cnt_max(CNT_W_DEFAULT));

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high, holds at all-ones.
module sat_counter
    import wr_ingress_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = W'(cnt_max(W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/wr_ingress_ctrl.sv
// Write-domain ingress: 2-entry skid buffer feeding the async FIFO write port,
// throttled by the registered full/almost-full flags, plus write/stall statistics.
module wr_ingress_ctrl
    import wr_ingress_pkg::*;
#(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             wclk_i,
    input  logic             wrst_i,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic             in_ready,
    input  logic             fifo_full,
    input  logic             fifo_almost_full,
    output logic             wen,
    output logic [DSIZE-1:0] wdata,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] stall_count,
    output logic             busy
);

    ingress_state_t   state_q, state_d;
    logic [DSIZE-1:0] main_q, main_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic             in_ready_d;
    logic             out_valid_c;
    logic             accept_c;

    assign out_valid_c = (state_q != EMPTY);
    assign accept_c    = in_valid & in_ready;
    // wen is a decode of registered state and the registered full flag only
    assign wen         = out_valid_c & ~fifo_full;
    assign wdata       = main_q;
    assign busy        = out_valid_c;

    // Occupancy FSM; main always holds the oldest word so wdata is stable while stalled
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept_c) begin
                    state_d = ONE;
                    main_d  = in_data;
                end
            end
            ONE: begin
                if (accept_c && !wen) begin
                    state_d = TWO;
                    skid_d  = in_data;
                end else if (accept_c && wen) begin
                    main_d  = in_data;
                end else if (wen) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (wen) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Almost-full keeps the skid slot free as headroom
        in_ready_d = (state_d == EMPTY) | ((state_d == ONE) & ~fifo_almost_full);
    end

    always_ff @(posedge wclk_i or posedge wrst_i) begin
        if (wrst_i) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            in_ready <= in_ready_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_wr_cnt (
        .clk   (wclk_i),
        .rst   (wrst_i),
        .inc   (wen),
        .count (wr_count)
    );

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (wclk_i),
        .rst   (wrst_i),
        .inc   (out_valid_c & fifo_full),
        .count (stall_count)
    );

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_wr_ingress_ctrl;

    logic        wclk_i = 1'b0;
    logic        wrst_i = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_almost_full = 1'b0;

    logic        in_ready, wen, busy;
    logic [7:0]  wdata;
    logic [15:0] wr_count, stall_count;
    logic        in_ready4, wen4, busy4;
    logic [7:0]  wdata4;
    logic [3:0]  wr_count4, stall_count4;

    always #5 wclk_i = ~wclk_i;

    wr_ingress_ctrl #(.DSIZE(8), .CNT_W(16)) dut (
        .wclk_i(wclk_i), .wrst_i(wrst_i), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .wen(wen), .wdata(wdata), .wr_count(wr_count), .stall_count(stall_count), .busy(busy)
    );

    wr_ingress_ctrl #(.DSIZE(8), .CNT_W(4)) dut4 (
        .wclk_i(wclk_i), .wrst_i(wrst_i), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready4), .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
        .wen(wen4), .wdata(wdata4), .wr_count(wr_count4), .stall_count(stall_count4), .busy(busy4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: accepted-but-unwritten words in order, plus counters
    logic [7:0] q[$];
    logic       m_ready = 1'b0;
    logic [7:0] m_last  = '0;
    int         m_wr    = 0;
    int         m_stall = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle: apply inputs, check at negedge, commit model after posedge
    task automatic cycle(input logic v, input logic [7:0] d, input logic f, input logic af,
                         output logic took);
        logic       exp_wen;
        logic [7:0] exp_wdata;
        logic       stalled;
        in_valid = v; in_data = d; fifo_full = f; fifo_almost_full = af;
        @(negedge wclk_i);
        exp_wen   = (q.size() > 0) && !f;
        exp_wdata = (q.size() > 0) ? q[0] : m_last;
        stalled   = (q.size() > 0) && f;
        check_eq("in_ready", 32'(in_ready), 32'(m_ready));
        check_eq("wen", 32'(wen), 32'(exp_wen));
        check_eq("wdata", 32'(wdata), 32'(exp_wdata));
        check_eq("busy", 32'(busy), 32'(q.size() > 0));
        check_eq("wr_count", 32'(wr_count), 32'(sat(m_wr, 65535)));
        check_eq("stall_count", 32'(stall_count), 32'(sat(m_stall, 65535)));
        check_eq("wen4", 32'(wen4), 32'(exp_wen));
        check_eq("wdata4", 32'(wdata4), 32'(exp_wdata));
        check_eq("in_ready4", 32'(in_ready4), 32'(m_ready));
        check_eq("busy4", 32'(busy4), 32'(q.size() > 0));
        check_eq("wr_count4", 32'(wr_count4), 32'(sat(m_wr, 15)));
        check_eq("stall_count4", 32'(stall_count4), 32'(sat(m_stall, 15)));
        took = v && m_ready;
        @(posedge wclk_i);
        #1;
        if (exp_wen) begin
            m_last = q.pop_front();
            m_wr++;
        end
        if (took) q.push_back(d);
        if (stalled) m_stall++;
        m_ready = (q.size() == 0) || ((q.size() == 1) && !af);
    endtask

    // Offer one word until accepted, bounded
    task automatic push(input logic [7:0] d, input logic f, input logic af);
        logic took;
        took = 1'b0;
        for (int i = 0; i < 20 && !took; i++) cycle(1'b1, d, f, af, took);
        if (!took) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout got=0 exp=1 data=%0h", d);
        end
    endtask

    task automatic idle(input int n, input logic f, input logic af);
        logic took;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, f, af, took);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge
    task automatic hit_reset();
        wrst_i = 1'b1;
        #1;
        check_eq("rst_wen", 32'(wen), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_wdata", 32'(wdata), 32'd0);
        check_eq("rst_wr_count", 32'(wr_count), 32'd0);
        check_eq("rst_stall_count", 32'(stall_count), 32'd0);
        q.delete();
        m_ready = 1'b0; m_last = '0; m_wr = 0; m_stall = 0;
        @(posedge wclk_i);
        @(posedge wclk_i);
        #1;
        wrst_i = 1'b0;
    endtask

    initial begin
        logic       took;
        logic       cur_v;
        logic [7:0] cur_d;

        @(posedge wclk_i);
        #1;
        hit_reset();

        // Streaming 0x01..0x10 at full rate
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        check_eq("stream_wr16", 32'(wr_count), 32'd16);
        check_eq("stream_stall0", 32'(stall_count), 32'd0);
        check_eq("stream_sat4", 32'(wr_count4), 32'd15);

        // FIFO full: fill to TWO, stall, then drain in order
        hit_reset();
        push(8'hA0, 1'b1, 1'b0);
        push(8'hA1, 1'b1, 1'b0);
        idle(4, 1'b1, 1'b0);
        check_eq("full_two_busy", 32'(busy), 32'd1);
        check_eq("full_two_ready", 32'(in_ready), 32'd0);
        check_eq("full_stall5", 32'(stall_count), 32'd5);
        idle(3, 1'b0, 1'b0);
        check_eq("full_wr2", 32'(wr_count), 32'd2);
        check_eq("full_last", 32'(wdata), 32'hA1);

        // Almost-full throttling: occupancy stays at one
        hit_reset();
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i), 1'b0, 1'b1);
        idle(2, 1'b0, 1'b1);
        check_eq("af_wr6", 32'(wr_count), 32'd6);

        // Accept and drain together in ONE
        hit_reset();
        for (int i = 0; i < 9; i++) push(8'(8'h80 + i), 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        check_eq("simul_wr9", 32'(wr_count), 32'd9);

        // Reset with two words buffered; they must never be written
        hit_reset();
        push(8'h55, 1'b1, 1'b0);
        push(8'h66, 1'b1, 1'b0);
        fifo_full = 1'b0;
        #1;
        check_eq("pre_rst_wen", 32'(wen), 32'd1);
        hit_reset();
        idle(3, 1'b0, 1'b0);
        check_eq("post_rst_wdata", 32'(wdata), 32'd0);
        push(8'h77, 1'b0, 1'b0);
        idle(2, 1'b0, 1'b0);
        check_eq("post_rst_wr1", 32'(wr_count), 32'd1);

        // Random traffic; producer holds data while not accepted
        cur_v = 1'b0;
        cur_d = '0;
        took  = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!cur_v || took) begin
                cur_v = ($urandom_range(0, 3) != 0);
                cur_d = 8'($urandom);
            end
            if ($urandom_range(0, 499) == 0) begin
                hit_reset();
                took = 1'b0;
            end else begin
                cycle(cur_v, cur_d, ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), took);
            end
        end
        idle(4, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
